// File: rtl/servant_pwr_pkg.sv
// Shared types for the servant LF power sequencer: FSM states and wake-cause codes.
package servant_pwr_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SLEEP  = 2'd2,
        SETTLE = 2'd3
    } PwrState;

    localparam logic [1:0] WAKE_NONE = 2'b00;
    localparam logic [1:0] WAKE_EVT  = 2'b01;
    localparam logic [1:0] WAKE_TMR  = 2'b10;
    localparam logic [1:0] WAKE_BOTH = 2'b11;

endpackage

// File: rtl/servant_pwr_sync.sv
// Two-flop synchronizer plus rising-edge detector; BYPASS=1 skips the sync
// stages for inputs that are already synchronous to clk_i.
module servant_pwr_sync #(
    parameter bit BYPASS = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic prev_q;

    generate
        if (BYPASS) begin : g_bypass
            assign level_o = d_i;
        end else begin : g_sync
            logic meta_q;
            logic sync_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                end else begin
                    meta_q <= d_i;
                    sync_q <= meta_q;
                end
            end

            assign level_o = sync_q;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_o;
        end
    end

    assign rise_o = level_o & ~prev_q;

endmodule

// File: rtl/servant_power_ctrl.sv
// LF-domain sequencer gating the HF oscillator and holding the core across sleep/wake.
// Optional sleep statistics counter enabled by `SERVANT_PWR_STATS_EN.
module servant_power_ctrl
    import servant_pwr_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int DRAIN_CYCLES  = 1,
    parameter int TIMER_W       = 16,
    parameter int STAT_W        = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sleep_req,
    input  logic               i_wake_evt,
    input  logic [TIMER_W-1:0] i_wake_period,
    output logic               o_hfosc_en,
    output logic               o_core_hold,
    output logic               o_asleep,
    output logic               o_wake_stb,
    output logic [1:0]         o_wake_src
`ifdef SERVANT_PWR_STATS_EN
    ,
    output logic [STAT_W-1:0]  o_sleep_count
`endif
);

    localparam int MAX_CYC = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || DRAIN_CYCLES < 1 || TIMER_W < 1 || STAT_W < 1) begin : g_bad_cfg
        $error("servant_power_ctrl: invalid parameter set");
    end

    PwrState            state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [TIMER_W-1:0] period_q, period_d;
    logic               fromSleep_q, fromSleep_d;
    logic               hfoscEn_q, hfoscEn_d;
    logic               coreHold_q, coreHold_d;
    logic               asleep_q, asleep_d;
    logic               wakeStb_q, wakeStb_d;
    logic [1:0]         wakeSrc_q, wakeSrc_d;

    logic wakeLevel, wakeRise;
    logic unusedSleepLevel, sleepRise;
    logic timerExpired;

    servant_pwr_sync #(.BYPASS(1'b0)) u_wakeSync (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .d_i     (i_wake_evt),
        .level_o (wakeLevel),
        .rise_o  (wakeRise)
    );

    servant_pwr_sync #(.BYPASS(1'b1)) u_sleepEdge (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .d_i     (i_sleep_req),
        .level_o (unusedSleepLevel),
        .rise_o  (sleepRise)
    );

    assign timerExpired = (period_q != '0) && (timer_q == (period_q - TIMER_W'(1)));

    // Reset lands in SETTLE so the core only runs once the HF clock has had time to start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= SETTLE;
            cnt_q       <= '0;
            timer_q     <= '0;
            period_q    <= '0;
            fromSleep_q <= 1'b0;
            hfoscEn_q   <= 1'b1;
            coreHold_q  <= 1'b1;
            asleep_q    <= 1'b0;
            wakeStb_q   <= 1'b0;
            wakeSrc_q   <= WAKE_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            period_q    <= period_d;
            fromSleep_q <= fromSleep_d;
            hfoscEn_q   <= hfoscEn_d;
            coreHold_q  <= coreHold_d;
            asleep_q    <= asleep_d;
            wakeStb_q   <= wakeStb_d;
            wakeSrc_q   <= wakeSrc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        period_d    = period_q;
        fromSleep_d = fromSleep_q;
        wakeSrc_d   = wakeSrc_q;
        wakeStb_d   = 1'b0;

        case (state_q)
            RUN: begin
                if (sleepRise && !wakeRise) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (wakeRise) begin
                    state_d     = SETTLE;
                    cnt_d       = '0;
                    wakeSrc_d   = WAKE_EVT;
                    fromSleep_d = 1'b0;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d  = SLEEP;
                    period_d = i_wake_period;
                    timer_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SLEEP: begin
                // A held-high synced event wakes too, so a level asserted before sleep is not lost.
                if (wakeLevel || timerExpired) begin
                    state_d     = SETTLE;
                    cnt_d       = '0;
                    wakeSrc_d   = {timerExpired, wakeLevel};
                    fromSleep_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d     = RUN;
                    wakeStb_d   = fromSleep_q;
                    fromSleep_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase

        hfoscEn_d  = (state_d != SLEEP);
        coreHold_d = (state_d != RUN);
        asleep_d   = (state_d == SLEEP);
    end

    assign o_hfosc_en  = hfoscEn_q;
    assign o_core_hold = coreHold_q;
    assign o_asleep    = asleep_q;
    assign o_wake_stb  = wakeStb_q;
    assign o_wake_src  = wakeSrc_q;

`ifdef SERVANT_PWR_STATS_EN
    // Counts completed sleeps only; a DRAIN abort never reaches SLEEP so it is excluded.
    logic [STAT_W-1:0] sleepCount_q;
    logic              sleepDone;

    assign sleepDone = (state_q == SLEEP) && (state_d == SETTLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sleepCount_q <= '0;
        end else if (sleepDone && !(&sleepCount_q)) begin
            sleepCount_q <= sleepCount_q + STAT_W'(1);
        end
    end

    assign o_sleep_count = sleepCount_q;
`endif

endmodule

// File: tb/tb_servant_power_ctrl.sv
// Directed bench for servant_power_ctrl; inputs change and outputs are sampled on negedge.
module tb_servant_power_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        sleepReq;
    logic        wakeEvt;
    logic [15:0] wakePeriod;
    logic        hfoscEn;
    logic        coreHold;
    logic        asleep;
    logic        wakeStb;
    logic [1:0]  wakeSrc;
`ifdef SERVANT_PWR_STATS_EN
    logic [1:0]  sleepCount;
`endif

    int checks = 0;
    int failures = 0;
    int toggleViolations = 0;
    bit monitorOn = 1'b0;
    logic prevHfosc, prevHold;

    always #5 clock = ~clock;

    servant_power_ctrl #(
        .SETTLE_CYCLES (2),
        .DRAIN_CYCLES  (1),
        .TIMER_W       (16),
        .STAT_W        (2)
    ) dut (
        .i_clk         (clock),
        .i_rst         (reset),
        .i_sleep_req   (sleepReq),
        .i_wake_evt    (wakeEvt),
        .i_wake_period (wakePeriod),
        .o_hfosc_en    (hfoscEn),
        .o_core_hold   (coreHold),
        .o_asleep      (asleep),
        .o_wake_stb    (wakeStb),
        .o_wake_src    (wakeSrc)
`ifdef SERVANT_PWR_STATS_EN
        ,
        .o_sleep_count (sleepCount)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic evt, input logic [15:0] per);
        sleepReq   = req;
        wakeEvt    = evt;
        wakePeriod = per;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Re-arms the sleep request, then returns at the first SLEEP cycle.
    task automatic enterSleep(input logic [15:0] per, input string tag);
        applyStimulus(1'b0, 1'b0, per);
        applyStimulus(1'b1, 1'b0, per);
        applyStimulus(1'b1, 1'b0, per);
        checkOutput(tag, asleep, 1'b1);
    endtask

    task automatic waitHoldLow(input string tag);
        int n = 0;
        while (coreHold !== 1'b0 && n < 30) begin
            @(negedge clock);
            n++;
        end
        checkOutput(tag, coreHold, 1'b0);
    endtask

    always @(negedge clock) begin
        if (monitorOn && (hfoscEn !== prevHfosc) && (coreHold !== prevHold))
            toggleViolations++;
        prevHfosc = hfoscEn;
        prevHold  = coreHold;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int stbSeen;
        reset = 1'b1; sleepReq = 1'b0; wakeEvt = 1'b0; wakePeriod = 16'd0;
        idle(2);
        checkOutput("rstHfosc", hfoscEn, 1'b1);
        checkOutput("rstHold", coreHold, 1'b1);
        checkOutput("rstAsleep", asleep, 1'b0);
        checkOutput("rstStb", wakeStb, 1'b0);
        checkOutput("rstSrc", wakeSrc, 2'b00);
        monitorOn = 1'b1;
        reset = 1'b0;
        idle(1);
        checkOutput("settle1Hold", coreHold, 1'b1);
        checkOutput("settle1Hfosc", hfoscEn, 1'b1);
        idle(1);
        checkOutput("runHold", coreHold, 1'b0);
        checkOutput("runStb", wakeStb, 1'b0);
        checkOutput("runSrc", wakeSrc, 2'b00);

        // Timer wake with period 5; period is changed mid-sleep and must be ignored.
        applyStimulus(1'b1, 1'b0, 16'd5);
        checkOutput("drainHold", coreHold, 1'b1);
        checkOutput("drainHfosc", hfoscEn, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'd5);
        checkOutput("sleepHfosc", hfoscEn, 1'b0);
        wakePeriod = 16'd100;
        n = 0;
        while (asleep === 1'b1 && n < 50) begin
            n++;
            @(negedge clock);
        end
        checkOutput("sleepLen5", n, 5);
        checkOutput("tmrSettleHfosc", hfoscEn, 1'b1);
        checkOutput("tmrSettleHold", coreHold, 1'b1);
        checkOutput("tmrSrc", wakeSrc, 2'b10);
        checkOutput("tmrStbEarly", wakeStb, 1'b0);
        idle(1);
        checkOutput("tmrSettle2Hold", coreHold, 1'b1);
        checkOutput("tmrSettle2Stb", wakeStb, 1'b0);
        idle(1);
        checkOutput("tmrRunHold", coreHold, 1'b0);
        checkOutput("tmrStb", wakeStb, 1'b1);
        checkOutput("tmrRunSrc", wakeSrc, 2'b10);
        idle(1);
        checkOutput("tmrStbOnce", wakeStb, 1'b0);

        // Event wake with the timer disabled: 3-cycle sync latency.
        enterSleep(16'd0, "evtAsleep");
        idle(4);
        checkOutput("timerOffAsleep", asleep, 1'b1);
        applyStimulus(1'b1, 1'b1, 16'd0);
        checkOutput("evtLat1", hfoscEn, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'd0);
        checkOutput("evtLat2", hfoscEn, 1'b0);
        idle(1);
        checkOutput("evtLat3", hfoscEn, 1'b1);
        checkOutput("evtHold3", coreHold, 1'b1);
        checkOutput("evtSrc", wakeSrc, 2'b01);
        idle(1);
        checkOutput("evtHold4", coreHold, 1'b1);
        idle(1);
        checkOutput("evtHold5", coreHold, 1'b0);
        checkOutput("evtStb", wakeStb, 1'b1);
        idle(5);
        checkOutput("noResleepHold", coreHold, 1'b0);
        checkOutput("noResleepAsleep", asleep, 1'b0);

        // Event and timer expiry on the same edge.
        enterSleep(16'd3, "bothAsleep");
        applyStimulus(1'b1, 1'b1, 16'd3);
        applyStimulus(1'b1, 1'b0, 16'd3);
        checkOutput("bothStillAsleep", asleep, 1'b1);
        idle(1);
        checkOutput("bothSrc", wakeSrc, 2'b11);
        checkOutput("bothHfosc", hfoscEn, 1'b1);
        waitHoldLow("bothRun");
        checkOutput("bothStb", wakeStb, 1'b1);

        // Sleep and wake edges together in RUN: sleep is discarded.
        applyStimulus(1'b0, 1'b0, 16'd0);
        applyStimulus(1'b0, 1'b1, 16'd0);
        applyStimulus(1'b0, 1'b0, 16'd0);
        applyStimulus(1'b1, 1'b0, 16'd0);
        checkOutput("discardHold", coreHold, 1'b0);
        idle(2);
        checkOutput("discardHold2", coreHold, 1'b0);
        checkOutput("discardAsleep", asleep, 1'b0);

        // Wake edge during DRAIN aborts back to RUN without a strobe.
        applyStimulus(1'b0, 1'b0, 16'd0);
        applyStimulus(1'b0, 1'b1, 16'd0);
        applyStimulus(1'b1, 1'b0, 16'd0);
        checkOutput("abortDrainHold", coreHold, 1'b1);
        checkOutput("abortDrainHfosc", hfoscEn, 1'b1);
        idle(1);
        checkOutput("abortHfosc", hfoscEn, 1'b1);
        checkOutput("abortAsleep", asleep, 1'b0);
        checkOutput("abortSrc", wakeSrc, 2'b01);
        stbSeen = 0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            if (wakeStb === 1'b1) stbSeen++;
        end
        checkOutput("abortNoStb", stbSeen, 0);
        checkOutput("abortRunHold", coreHold, 1'b0);

        // Reset in the middle of SLEEP.
        enterSleep(16'd0, "rstSleepAsleep");
        reset = 1'b1;
        idle(1);
        checkOutput("midRstHfosc", hfoscEn, 1'b1);
        checkOutput("midRstHold", coreHold, 1'b1);
        checkOutput("midRstAsleep", asleep, 1'b0);
        checkOutput("midRstSrc", wakeSrc, 2'b00);
`ifdef SERVANT_PWR_STATS_EN
        checkOutput("midRstCount", sleepCount, 2'd0);
`endif
        reset = 1'b0;
        idle(1);
        checkOutput("midRstSettleHold", coreHold, 1'b1);
        idle(1);
        checkOutput("midRstRunHold", coreHold, 1'b0);
        checkOutput("midRstNoStb", wakeStb, 1'b0);
        checkOutput("midRstNoSleep", asleep, 1'b0);

        // Five period-1 sleeps; each lasts exactly one SLEEP cycle.
        for (int i = 0; i < 5; i++) begin
            enterSleep(16'd1, "p1Asleep");
            idle(1);
            checkOutput("p1Len", asleep, 1'b0);
            waitHoldLow("p1Run");
`ifdef SERVANT_PWR_STATS_EN
            checkOutput("statCount", sleepCount, (i + 1 > 3) ? 3 : i + 1);
`endif
        end
`ifdef SERVANT_PWR_STATS_EN
        checkOutput("statSaturated", sleepCount, 2'd3);
`endif

        checkOutput("noSimulToggle", toggleViolations, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
